// File: rtl/seg7_scan_reader.sv
// Receive side of a multiplexed, active-low 7-segment display bus: synchronizes
// segments and digit enables, waits for a stable pattern and decodes it back to hex.
// Optional macro SEG7_READER_BLANK_EN treats an all-dark digit as a legal blank.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int IDX_W         = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              i_seg_n,
    input  logic [NUM_DIGITS-1:0]   i_dig_n,
    output logic                    o_cap_valid,
    output logic [IDX_W-1:0]        o_cap_digit,
    output logic [3:0]              o_cap_value,
    output logic                    o_cap_dp,
    output logic                    o_cap_err,
`ifdef SEG7_READER_BLANK_EN
    output logic                    o_cap_blank,
`endif
    output logic [4*NUM_DIGITS-1:0] o_digits,
    output logic                    o_frame_valid
);

    localparam int         S_W     = 8 + NUM_DIGITS;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        SETTLE,
        EMIT,
        HOLD
    } state_t;

    logic [7:0]            r_segMeta;
    logic [7:0]            r_segSync;
    logic [NUM_DIGITS-1:0] r_digMeta;
    logic [NUM_DIGITS-1:0] r_digSync;
    logic [S_W-1:0]        r_prevS;
    logic [7:0]            r_cnt;
    state_t                r_state;
    state_t                w_stateNext;

    logic                    r_capValid;
    logic [IDX_W-1:0]        r_capDigit;
    logic [3:0]              r_capValue;
    logic                    r_capDp;
    logic                    r_capErr;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    r_frameValid;

    logic [S_W-1:0]        w_S;
    logic                  w_changed;
    logic [NUM_DIGITS-1:0] w_digLow;
    logic                  w_oneHot;
    logic [IDX_W-1:0]      w_lowIdx;
    logic [6:0]            w_pattern;
    logic [3:0]            w_decValue;
    logic                  w_decErr;
    logic                  w_goEmit;
`ifdef SEG7_READER_BLANK_EN
    logic                  w_decBlank;
    logic                  r_capBlank;
`endif

    // Both buses are asynchronous to clk; idle (all high) is the safe reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segMeta <= '1;
            r_segSync <= '1;
            r_digMeta <= '1;
            r_digSync <= '1;
            r_prevS   <= '1;
        end else begin
            r_segMeta <= i_seg_n;
            r_segSync <= r_segMeta;
            r_digMeta <= i_dig_n;
            r_digSync <= r_digMeta;
            r_prevS   <= w_S;
        end
    end

    assign w_S       = {r_segSync, r_digSync};
    assign w_changed = (w_S != r_prevS);
    assign w_digLow  = ~r_digSync;
    assign w_oneHot  = (w_digLow != '0) && ((w_digLow & (w_digLow - NUM_DIGITS'(1))) == '0);
    assign w_pattern = ~r_segSync[6:0];

    always_comb begin
        w_lowIdx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (w_digLow[i]) begin
                w_lowIdx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_decValue = 4'h0;
        w_decErr   = 1'b0;
`ifdef SEG7_READER_BLANK_EN
        w_decBlank = 1'b0;
`endif
        case (w_pattern)
            7'h7E: w_decValue = 4'h0;
            7'h30: w_decValue = 4'h1;
            7'h6D: w_decValue = 4'h2;
            7'h79: w_decValue = 4'h3;
            7'h33: w_decValue = 4'h4;
            7'h5B: w_decValue = 4'h5;
            7'h5F: w_decValue = 4'h6;
            7'h70: w_decValue = 4'h7;
            7'h7F: w_decValue = 4'h8;
            7'h7B: w_decValue = 4'h9;
            7'h77: w_decValue = 4'hA;
            7'h1F: w_decValue = 4'hB;
            7'h4E: w_decValue = 4'hC;
            7'h3D: w_decValue = 4'hD;
            7'h4F: w_decValue = 4'hE;
            7'h47: w_decValue = 4'hF;
`ifdef SEG7_READER_BLANK_EN
            7'h00: w_decBlank = 1'b1;
`endif
            default: w_decErr = 1'b1;
        endcase
    end

    // Counts consecutive identical one-hot samples, saturating at the capture threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (w_changed || !w_oneHot) begin
            r_cnt <= 8'd0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SETTLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A saturated counter in HOLD means nothing has changed since the capture.
    always_comb begin
        w_stateNext = r_state;
        w_goEmit    = 1'b0;
        case (r_state)
            SETTLE: begin
                if (r_cnt == CNT_MAX && w_oneHot && !w_changed) begin
                    w_goEmit    = 1'b1;
                    w_stateNext = EMIT;
                end
            end
            EMIT: w_stateNext = HOLD;
            HOLD: begin
                if (w_changed || r_cnt != CNT_MAX) begin
                    w_stateNext = SETTLE;
                end
            end
            default: w_stateNext = SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_capValid <= 1'b0;
            r_capDigit <= '0;
            r_capValue <= 4'h0;
            r_capDp    <= 1'b0;
            r_capErr   <= 1'b0;
`ifdef SEG7_READER_BLANK_EN
            r_capBlank <= 1'b0;
`endif
        end else begin
            r_capValid <= w_goEmit;
            if (w_goEmit) begin
                r_capDigit <= w_lowIdx;
                r_capValue <= w_decValue;
                r_capDp    <= ~r_segSync[7];
                r_capErr   <= w_decErr;
`ifdef SEG7_READER_BLANK_EN
                r_capBlank <= w_decBlank;
`endif
            end
        end
    end

    // The seen mask is complete during the EMIT cycle, so the frame pulse lands one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits     <= '0;
            r_seen       <= '0;
            r_frameValid <= 1'b0;
        end else begin
            r_frameValid <= 1'b0;
            if (r_state == EMIT && (&r_seen)) begin
                r_frameValid <= 1'b1;
                r_seen       <= '0;
            end else if (w_goEmit && !w_decErr) begin
                r_seen[w_lowIdx] <= 1'b1;
`ifdef SEG7_READER_BLANK_EN
                if (!w_decBlank) begin
                    r_digits[{w_lowIdx, 2'b00} +: 4] <= w_decValue;
                end
`else
                r_digits[{w_lowIdx, 2'b00} +: 4] <= w_decValue;
`endif
            end
        end
    end

    assign o_cap_valid   = r_capValid;
    assign o_cap_digit   = r_capDigit;
    assign o_cap_value   = r_capValue;
    assign o_cap_dp      = r_capDp;
    assign o_cap_err     = r_capErr;
    assign o_digits      = r_digits;
    assign o_frame_valid = r_frameValid;
`ifdef SEG7_READER_BLANK_EN
    assign o_cap_blank   = r_capBlank;
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: directed vector table, frame and reset
// sequences, then randomized bus activity against a sample-window reference model.
module tb_seg7_scan_reader;

    localparam int ND = 4;
    localparam int SC = 16;
    localparam int IW = 2;

    logic          clk;
    logic          rst_n;
    logic [7:0]    seg_n;
    logic [ND-1:0] dig_n;
    logic          cap_valid;
    logic [IW-1:0] cap_digit;
    logic [3:0]    cap_value;
    logic          cap_dp;
    logic          cap_err;
    logic [4*ND-1:0] digits;
    logic          frame_valid;
`ifdef SEG7_READER_BLANK_EN
    logic          cap_blank;
`endif

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .IDX_W(IW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_seg_n       (seg_n),
        .i_dig_n       (dig_n),
        .o_cap_valid   (cap_valid),
        .o_cap_digit   (cap_digit),
        .o_cap_value   (cap_value),
        .o_cap_dp      (cap_dp),
        .o_cap_err     (cap_err),
`ifdef SEG7_READER_BLANK_EN
        .o_cap_blank   (cap_blank),
`endif
        .o_digits      (digits),
        .o_frame_valid (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;

    logic [6:0] patTab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model: a capture happens when the last SC+1 synchronized samples are
    // identical and one-hot, and is not repeated until the sample moves off that value.
    logic [11:0] m_meta;
    logic [11:0] m_hist [$];
    logic [11:0] m_capS;
    bit          m_armed;
    bit          m_prevCap;
    logic [3:0]  m_seen;
    logic        e_capValid;
    logic [1:0]  e_capDigit;
    logic [3:0]  e_capValue;
    logic        e_capDp;
    logic        e_capErr;
    logic [15:0] e_digits;
    logic        e_frame;

    function automatic void decodeModel(input logic [6:0] p, output logic [3:0] v,
                                        output logic err, output logic blank);
        v = 4'h0;
        err = 1'b1;
        blank = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (patTab[i] == p) begin
                v = 4'(i);
                err = 1'b0;
            end
        end
`ifdef SEG7_READER_BLANK_EN
        if (p == 7'h00) begin
            err = 1'b0;
            blank = 1'b1;
        end
`endif
    endfunction

    task automatic modelReset();
        m_meta = '1;
        m_hist.delete();
        m_hist.push_back('1);
        m_capS = '1;
        m_armed = 1'b1;
        m_prevCap = 1'b0;
        m_seen = '0;
        e_capValid = 1'b0;
        e_capDigit = '0;
        e_capValue = '0;
        e_capDp = 1'b0;
        e_capErr = 1'b0;
        e_digits = '0;
        e_frame = 1'b0;
    endtask

    task automatic modelEdge(input logic [11:0] pin);
        logic [11:0] s;
        logic [3:0]  v;
        logic        err;
        logic        blank;
        bit          ok;
        int          d;
        e_frame = 1'b0;
        if (m_prevCap && m_seen == 4'hF) begin
            e_frame = 1'b1;
            m_seen = '0;
        end
        e_capValid = 1'b0;
        s = m_hist[$];
        ok = m_armed && (m_hist.size() == SC + 1) && ($countones(~s[3:0]) == 1);
        foreach (m_hist[k]) if (m_hist[k] != s) ok = 1'b0;
        if (ok) begin
            e_capValid = 1'b1;
            m_armed = 1'b0;
            m_capS = s;
            d = 0;
            for (int k = 3; k >= 0; k--) if (!s[k]) d = k;
            decodeModel(~s[10:4], v, err, blank);
            e_capDigit = 2'(d);
            e_capValue = v;
            e_capDp = ~s[11];
            e_capErr = err;
            if (!err) begin
                m_seen[d] = 1'b1;
                if (!blank) e_digits[d*4 +: 4] = v;
            end
        end
        m_prevCap = e_capValid;
        m_hist.push_back(m_meta);
        if (m_hist.size() > SC + 1) void'(m_hist.pop_front());
        if (!m_armed && m_meta != m_capS) m_armed = 1'b1;
        m_meta = pin;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic [25:0] act;
        logic [25:0] exp;
        act = {cap_valid, cap_digit, cap_value, cap_dp, cap_err, digits, frame_valid};
        exp = {e_capValid, e_capDigit, e_capValue, e_capDp, e_capErr, e_digits, e_frame};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL cycle %0d outputs {valid,digit,value,dp,err,digits,frame}: got %h expected %h",
                     cycleNo, act, exp);
        end
    endtask

    // Called just after a falling edge: drive pins, step model at the rising edge, check on the next fall.
    task automatic applyStimulus(input logic [7:0] seg, input logic [3:0] dig);
        seg_n = seg;
        dig_n = dig;
        @(posedge clk);
        modelEdge({seg, dig});
        @(negedge clk);
        cycleNo++;
        checkOutput();
    endtask

    typedef struct {
        logic [7:0]  seg;
        logic [3:0]  dig;
        int          hold;
        int          expCaps;
        int          expCycle;
        logic [1:0]  expDigit;
        logic [3:0]  expValue;
        logic        expDp;
        logic        expErr;
        logic [15:0] expDigits;
    } vec_t;

    vec_t vecs [6];
    logic [7:0] frameSeg [4] = '{8'hCF, 8'h92, 8'h86, 8'hCC};

    initial begin
        int actCaps;
        int first;
        int frames;
        int passFrames;
        logic [3:0] one;
        logic [7:0] rseg;
        logic [3:0] rdig;

        vecs[0] = '{8'hA4, 4'b1110, 30, 1, SC + 3, 2'd0, 4'h5, 1'b0, 1'b0, 16'h0005};
        vecs[1] = '{8'h81, 4'b1110, 10, 0, 0, 2'd0, 4'h5, 1'b0, 1'b0, 16'h0005};
        vecs[2] = '{8'hCF, 4'b1110, 30, 1, SC + 3, 2'd0, 4'h1, 1'b0, 1'b0, 16'h0001};
        vecs[3] = '{8'hA4, 4'b1100, 40, 0, 0, 2'd0, 4'h1, 1'b0, 1'b0, 16'h0001};
        vecs[4] = '{8'hA4, 4'b1111, 40, 0, 0, 2'd0, 4'h1, 1'b0, 1'b0, 16'h0001};
        vecs[5] = '{8'h7E, 4'b1011, 30, 1, SC + 3, 2'd2, 4'h0, 1'b1, 1'b1, 16'h0001};

        rst_n = 1'b0;
        seg_n = '1;
        dig_n = '1;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput();
        rst_n = 1'b1;

        // First capture lands on cycle 2+SC counting the first sampling edge as cycle 0, i.e. edge SC+3.
        foreach (vecs[v]) begin
            actCaps = 0;
            first = 0;
            for (int c = 1; c <= vecs[v].hold; c++) begin
                applyStimulus(vecs[v].seg, vecs[v].dig);
                if (cap_valid) begin
                    actCaps++;
                    if (first == 0) first = c;
                end
            end
            checkVal($sformatf("vec%0d capture count", v), actCaps, vecs[v].expCaps);
            checkVal($sformatf("vec%0d digits", v), digits, vecs[v].expDigits);
            if (vecs[v].expCaps == 1) begin
                checkVal($sformatf("vec%0d capture edge", v), first, vecs[v].expCycle);
                checkVal($sformatf("vec%0d cap_digit", v), cap_digit, vecs[v].expDigit);
                checkVal($sformatf("vec%0d cap_value", v), cap_value, vecs[v].expValue);
                checkVal($sformatf("vec%0d cap_dp", v), cap_dp, vecs[v].expDp);
                checkVal($sformatf("vec%0d cap_err", v), cap_err, vecs[v].expErr);
            end
        end

        frames = 0;
        one = 4'b0001;
        for (int pass = 0; pass < 2; pass++) begin
            passFrames = 0;
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 20; c++) begin
                    applyStimulus(frameSeg[d], ~(one << d));
                    if (frame_valid) passFrames++;
                end
            end
            checkVal($sformatf("frame pulses in pass %0d", pass), passFrames, 1);
            frames += passFrames;
        end
        checkVal("frame pulses total", frames, 2);
        checkVal("frame digits", digits, 16'h4321);

        for (int c = 0; c < 10; c++) applyStimulus(8'hA4, 4'b1101);
        #2 rst_n = 1'b0;
        #1;
        checkVal("reset cap_valid", cap_valid, 0);
        checkVal("reset cap_value", cap_value, 0);
        checkVal("reset cap_digit", cap_digit, 0);
        checkVal("reset digits", digits, 0);
        checkVal("reset frame_valid", frame_valid, 0);
        repeat (3) @(negedge clk);
        checkVal("reset held digits", digits, 0);
        modelReset();
        rst_n = 1'b1;
        first = 0;
        for (int c = 1; c <= 30; c++) begin
            applyStimulus(8'hA4, 4'b1101);
            if (cap_valid && first == 0) first = c;
        end
        checkVal("capture edge after reset", first, SC + 3);
        checkVal("digits after reset capture", digits, 16'h0050);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(9, 0) < 7)
                rseg = ~{1'($urandom_range(1, 0)), patTab[$urandom_range(15, 0)]};
            else
                rseg = 8'($urandom());
            if ($urandom_range(3, 0) != 0)
                rdig = ~(one << $urandom_range(3, 0));
            else
                rdig = 4'($urandom());
            for (int c = $urandom_range(25, 1); c > 0; c--) applyStimulus(rseg, rdig);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receive side of the board's multiplexed 7-segment display bus. Samples active-low segment lines and active-low digit enables.
- Waits until the sampled pattern is stable, then inverts the hex segment encoding back to a 4-bit value per digit position.
- Used for loopback self-test of display drivers and for reading a display driven by another board.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (2..8)
- STABLE_CYCLES, 16, consecutive identical synchronized samples required before capture (2..255)
- IDX_W, 2, width of digit index, must satisfy 2**IDX_W >= NUM_DIGITS

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg_n  input  8  active-low segments: bit7 = dp, bit6 = a ... bit0 = g; asynchronous to clk
- dig_n  input  NUM_DIGITS  active-low digit enables, one low at a time when valid; asynchronous
- cap_valid  output  1  one-cycle pulse per capture
- cap_digit  output  IDX_W  index of the low dig_n bit for this capture
- cap_value  output  4  decoded hex value
- cap_dp  output  1  decimal point, active-high
- cap_err  output  1  qualifies cap_valid: pattern not in decode table
- digits  output  4*NUM_DIGITS  last good value per digit; digit i at [4i+3:4i]
- frame_valid  output  1  one-cycle pulse when every digit has had a good capture since the last frame_valid

Behaviour:
- Input synchronization:
  - seg_n and dig_n each pass through a 2-flop synchronizer.
  - All logic below uses the synchronized sample S = {seg_n, dig_n}.
- Segment decode: active-high pattern P = ~seg_n[6:0].
  - 0:7E, 1:30, 2:6D, 3:79, 4:33, 5:5B, 6:5F, 7:70, 8:7F, 9:7B, A:77, b:1F, C:4E, d:3D, E:4F, F:47 (hex of P).
  - Any other P gives cap_err=1 and cap_value=0.
  - cap_dp = ~seg_n[7].
- Stability counter:
  - Width 8. Cleared whenever S differs from the previous-cycle S, or dig_n is not one-hot-low (all high, or more than one low).
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- FSM states:
  - SETTLE: counter running. When the counter equals STABLE_CYCLES-1 and dig_n is one-hot-low, go to EMIT.
  - EMIT: one cycle.
    - cap_valid=1; cap_digit, cap_value, cap_dp, cap_err driven from S.
    - If cap_err=0, write cap_value into digits[cap_digit] and set seen[cap_digit].
    - Go to HOLD.
  - HOLD: no further capture. On any change of S, clear the counter and go to SETTLE. A static display therefore produces exactly one capture per digit.
- Outputs outside EMIT:
  - cap_valid=0.
  - cap_digit/cap_value/cap_dp/cap_err hold their last EMIT values.
- Frame tracking:
  - Internal seen[NUM_DIGITS] register.
  - When seen becomes all ones in an EMIT cycle, frame_valid=1 in the following cycle and seen clears to 0 in the same cycle.
  - Error captures do not set seen.
- Latency: a pin change stable from cycle 0 gives cap_valid at cycle 2+STABLE_CYCLES (2 sync, STABLE_CYCLES counting, EMIT registered).
- Boundary cases:
  - Glitch shorter than STABLE_CYCLES: no capture.
  - Same digit recaptured after a change: overwrites digits[i].
  - S changes during the EMIT cycle: EMIT still completes with the pre-change sample; HOLD then sees the change and returns to SETTLE.
  - cap_digit encoding: index of the lowest low bit; one-hot is guaranteed at EMIT.
- Reset (asynchronous, any state):
  - Synchronizers to all ones.
  - Counter 0; state SETTLE; seen 0.
  - cap_valid, cap_digit, cap_value, cap_dp, cap_err, digits, frame_valid all 0.

Optional Feature:
- Macro SEG7_READER_BLANK_EN.
- Defined:
  - P=00 (all segments dark) is a legal blank.
  - EMIT gives cap_err=0 and cap_value=0; digits[i] is unchanged; seen[i] is set.
  - Adds output cap_blank (1 bit, reset 0, valid with cap_valid).
- Undefined:
  - P=00 is reported as cap_err=1.
  - No cap_blank port.

Test Plan:
- Decode one digit: seg_n=8'hA4, dig_n=4'b1110 held 30 cycles -> exactly one cap_valid, at cycle 18 with STABLE_CYCLES=16; cap_digit=0, cap_value=5, cap_dp=0, cap_err=0; digits[3:0]=5.
- Glitch rejection: seg_n=8'h81 (digit 0 pattern) for 10 cycles, then seg_n=8'hCF (digit 1 pattern) held -> no capture for the 10-cycle pattern; single capture of value 1.
- Illegal enables: dig_n=4'b1100, then 4'b1111, each held 40 cycles -> no cap_valid.
- Bad pattern and dp: seg_n=8'h7E (P=01, dp lit), dig_n=4'b1011 -> cap_err=1, cap_dp=1, cap_digit=2; digits unchanged.
- Frame: scan digits 0..3 with values 1,2,3,4, each held 20 cycles, repeated twice -> frame_valid once per scan pass; digits=16'h4321.
- Reset mid-count: assert rst_n=0 at cycle 10 of SETTLE, release and hold the same input -> all outputs 0 during reset; first capture 18 cycles after release.
